// File: rtl/uart_wb_bridge.sv
// WISHBONE slave front-end for the UART16550 register file: one core strobe per bus cycle, ack WAIT_STATES+1 cycles after it.
// Illegal byte selects end in a one-cycle err, and dropping cyc mid-transfer abandons it silently.
module uart_wb_bridge #(
   parameter int ADDR_WIDTH  = 5,
   parameter int DATA_WIDTH  = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic                    clk,
   input  logic                    wb_rst_n_i,
   input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
   input  logic                    wb_we_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_cyc_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,
   output logic [ADDR_WIDTH-1:0]   reg_adr_o,
   output logic [7:0]              reg_dat_o,
   output logic                    reg_we_o,
   output logic                    reg_re_o,
   input  logic [7:0]              reg_dat_i
);

   localparam int         SEL_W    = DATA_WIDTH / 8;
   localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [2:0] {IDLE, ACCESS, WAIT, ACK, ERR} state_t;

   state_t                  state, state_nxt;
   logic [3:0]              cnt;
   logic                    we_q;
   logic [1:0]              lane_q;
   logic [7:0]              hold;
   logic                    req, sel_ok, start;
   logic [2:0]              sel_cnt;
   logic [1:0]              sel_lane;
   logic [ADDR_WIDTH-1:0]   req_adr;
   logic [7:0]              req_dat, rd_src;
   logic [DATA_WIDTH-1:0]   rd_word;

   assign req = wb_cyc_i & wb_stb_i;

   // One-hot select check and lane/byte decode of the incoming request.
   always_comb begin
      sel_cnt  = '0;
      sel_lane = '0;
      req_dat  = wb_dat_i[7:0];
      for (int i = 0; i < SEL_W; i++) begin
         if (wb_sel_i[i]) begin
            sel_cnt  = sel_cnt + 3'd1;
            sel_lane = 2'(i);
         end
      end
      for (int i = 0; i < SEL_W; i++) begin
         if (sel_lane == 2'(i)) req_dat = wb_dat_i[8*i +: 8];
      end
      req_adr = wb_adr_i;
      if (DATA_WIDTH == 32) req_adr[1:0] = sel_lane;
   end

   assign sel_ok = (DATA_WIDTH == 8) || (sel_cnt == 3'd1);

   // With no wait states the ACCESS cycle feeds ACK directly, before hold is loaded.
   always_comb begin
      rd_src  = (state == ACCESS) ? reg_dat_i : hold;
      rd_word = '0;
      for (int i = 0; i < SEL_W; i++) begin
         if (lane_q == 2'(i)) rd_word[8*i +: 8] = rd_src;
      end
   end

   always_ff @(posedge clk or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) state <= IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = sel_ok ? ACCESS : ERR;
         ACCESS:  if (!wb_cyc_i)             state_nxt = IDLE;
                  else if (WAIT_STATES > 0)  state_nxt = WAIT;
                  else                       state_nxt = ACK;
         WAIT:    if (!wb_cyc_i)             state_nxt = IDLE;
                  else if (cnt == 4'd0)      state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign start = (state == IDLE) && (state_nxt == ACCESS);

   // Outputs are registered from the next state so strobe/ack/err line up with the state they belong to.
   always_ff @(posedge clk or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         cnt       <= '0;
         we_q      <= 1'b0;
         lane_q    <= '0;
         hold      <= '0;
         reg_adr_o <= '0;
         reg_dat_o <= '0;
         reg_we_o  <= 1'b0;
         reg_re_o  <= 1'b0;
         wb_ack_o  <= 1'b0;
         wb_err_o  <= 1'b0;
         wb_dat_o  <= '0;
      end else begin
         reg_we_o <= start & wb_we_i;
         reg_re_o <= start & ~wb_we_i;
         wb_ack_o <= (state_nxt == ACK);
         wb_err_o <= (state_nxt == ERR);
         if (state == IDLE && req) begin
            we_q      <= wb_we_i;
            lane_q    <= sel_lane;
            reg_adr_o <= req_adr;
            reg_dat_o <= req_dat;
         end
         if (state == ACCESS) begin
            hold <= reg_dat_i;
            cnt  <= CNT_LOAD;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (state_nxt == ACK && !we_q) wb_dat_o <= rd_word;
      end
   end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Bench for uart_wb_bridge: three instances (8-bit W=1, 32-bit W=0, 32-bit W=5) driven
// per scenario, with expected strobes and read data queued at drive time and popped on output.
module tb_uart_wb_bridge;

   typedef struct packed {
      logic [4:0] adr;
      logic [7:0] dat;
      logic       we;
      logic       chk_dat;
   } stb_exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   stb_exp_t    sq[$];
   logic [31:0] aq[$];

   always #5 clk = ~clk;

   function automatic logic [7:0] core_rd(input logic [4:0] a);
      return 8'h56 + {3'b000, a};
   endfunction

   // Instance A: 8-bit bus, one wait state
   logic [4:0] a_adr, a_reg_adr;
   logic [7:0] a_wdat, a_rdat, a_reg_dat, a_core;
   logic [0:0] a_sel;
   logic       a_we, a_stb, a_cyc, a_ack, a_err, a_reg_we, a_reg_re;
   assign a_core = core_rd(a_reg_adr);

   uart_wb_bridge #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .WAIT_STATES(1)) u_a (
      .clk(clk), .wb_rst_n_i(rst_n), .wb_adr_i(a_adr), .wb_dat_i(a_wdat), .wb_sel_i(a_sel),
      .wb_we_i(a_we), .wb_stb_i(a_stb), .wb_cyc_i(a_cyc), .wb_dat_o(a_rdat), .wb_ack_o(a_ack),
      .wb_err_o(a_err), .reg_adr_o(a_reg_adr), .reg_dat_o(a_reg_dat), .reg_we_o(a_reg_we),
      .reg_re_o(a_reg_re), .reg_dat_i(a_core));

   // Instance B: 32-bit bus, no wait states
   logic [4:0]  b_adr, b_reg_adr;
   logic [31:0] b_wdat, b_rdat;
   logic [7:0]  b_reg_dat, b_core;
   logic [3:0]  b_sel;
   logic        b_we, b_stb, b_cyc, b_ack, b_err, b_reg_we, b_reg_re;
   assign b_core = core_rd(b_reg_adr);

   uart_wb_bridge #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .WAIT_STATES(0)) u_b (
      .clk(clk), .wb_rst_n_i(rst_n), .wb_adr_i(b_adr), .wb_dat_i(b_wdat), .wb_sel_i(b_sel),
      .wb_we_i(b_we), .wb_stb_i(b_stb), .wb_cyc_i(b_cyc), .wb_dat_o(b_rdat), .wb_ack_o(b_ack),
      .wb_err_o(b_err), .reg_adr_o(b_reg_adr), .reg_dat_o(b_reg_dat), .reg_we_o(b_reg_we),
      .reg_re_o(b_reg_re), .reg_dat_i(b_core));

   // Instance C: 32-bit bus, five wait states
   logic [4:0]  c_adr, c_reg_adr;
   logic [31:0] c_wdat, c_rdat;
   logic [7:0]  c_reg_dat, c_core;
   logic [3:0]  c_sel;
   logic        c_we, c_stb, c_cyc, c_ack, c_err, c_reg_we, c_reg_re;
   assign c_core = core_rd(c_reg_adr);

   uart_wb_bridge #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .WAIT_STATES(5)) u_c (
      .clk(clk), .wb_rst_n_i(rst_n), .wb_adr_i(c_adr), .wb_dat_i(c_wdat), .wb_sel_i(c_sel),
      .wb_we_i(c_we), .wb_stb_i(c_stb), .wb_cyc_i(c_cyc), .wb_dat_o(c_rdat), .wb_ack_o(c_ack),
      .wb_err_o(c_err), .reg_adr_o(c_reg_adr), .reg_dat_o(c_reg_dat), .reg_we_o(c_reg_we),
      .reg_re_o(c_reg_re), .reg_dat_i(c_core));

   task automatic test_reset();
      a_adr = '0; a_wdat = '0; a_sel = '0; a_we = 0; a_stb = 0; a_cyc = 0;
      b_adr = '0; b_wdat = '0; b_sel = '0; b_we = 0; b_stb = 0; b_cyc = 0;
      c_adr = '0; c_wdat = '0; c_sel = '0; c_we = 0; c_stb = 0; c_cyc = 0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int pass = 0; pass < 2; pass++) begin
         checks++;
         if ({a_rdat, a_ack, a_err, a_reg_adr, a_reg_dat, a_reg_we, a_reg_re} !== '0) begin
            errors++;
            $display("FAIL reset_a[%0d]: dat=%h ack=%b err=%b adr=%h rdat=%h we=%b re=%b, required all 0",
                     pass, a_rdat, a_ack, a_err, a_reg_adr, a_reg_dat, a_reg_we, a_reg_re);
         end
         checks++;
         if ({b_rdat, b_ack, b_err, b_reg_adr, b_reg_dat, b_reg_we, b_reg_re,
              c_rdat, c_ack, c_err, c_reg_adr, c_reg_dat, c_reg_we, c_reg_re} !== '0) begin
            errors++;
            $display("FAIL reset_bc[%0d]: b_dat=%h c_dat=%h b_adr=%h c_adr=%h, required all outputs 0",
                     pass, b_rdat, c_rdat, b_reg_adr, c_reg_adr);
         end
         rst_n = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic test_write8();
      stb_exp_t e;
      int nstb = 0;
      int nack = 0;
      @(negedge clk);
      sq.push_back('{adr: 5'd3, dat: 8'hA5, we: 1'b1, chk_dat: 1'b1});
      a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 5'd3; a_wdat = 8'hA5; a_sel = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if ((a_reg_we && a_reg_re) || a_err) begin
            errors++;
            $display("FAIL write8_excl k=%0d: we=%b re=%b err=%b, required not both strobes and no err",
                     k, a_reg_we, a_reg_re, a_err);
         end
         if (a_reg_we || a_reg_re) begin
            nstb++;
            checks++;
            if (sq.size() == 0) begin
               errors++;
               $display("FAIL write8_strobe k=%0d: strobe seen, required none", k);
            end else begin
               e = sq.pop_front();
               if (k != 0 || a_reg_adr !== e.adr || a_reg_we !== e.we || a_reg_dat !== e.dat) begin
                  errors++;
                  $display("FAIL write8_strobe: k=%0d adr=%h dat=%h we=%b, required k=0 adr=%h dat=%h we=%b",
                           k, a_reg_adr, a_reg_dat, a_reg_we, e.adr, e.dat, e.we);
               end
            end
         end
         if (a_ack) begin
            nack++;
            checks++;
            if (k != 2) begin
               errors++;
               $display("FAIL write8_ack_cycle: ack at k=%0d, required k=2", k);
            end
            a_cyc = 0; a_stb = 0;
         end
      end
      checks++;
      if (nstb != 1 || nack != 1) begin
         errors++;
         $display("FAIL write8_count: strobes=%0d acks=%0d, required 1 and 1", nstb, nack);
      end
   endtask

   task automatic test_read32();
      logic [4:0]  t_adr  [4] = '{5'h04, 5'h08, 5'h13, 5'h1C};
      logic [3:0]  t_sel  [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
      logic        t_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] t_wd   [4] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0000_7700};
      logic [4:0]  t_radr [4] = '{5'h06, 5'h0B, 5'h10, 5'h1D};
      logic [7:0]  t_rdat [4] = '{8'h00, 8'hDE, 8'h00, 8'h77};
      stb_exp_t    e;
      logic [31:0] exp_w;
      for (int i = 0; i < 4; i++) begin
         int nstb;
         int nack;
         nstb = 0;
         nack = 0;
         @(negedge clk);
         sq.push_back('{adr: t_radr[i], dat: t_rdat[i], we: t_we[i], chk_dat: t_we[i]});
         if (!t_we[i]) begin
            exp_w = {24'h0, core_rd(t_radr[i])} << {t_radr[i][1:0], 3'b000};
            aq.push_back(exp_w);
         end
         b_cyc = 1; b_stb = 1; b_we = t_we[i]; b_adr = t_adr[i]; b_wdat = t_wd[i]; b_sel = t_sel[i];
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (b_reg_we || b_reg_re) begin
               nstb++;
               checks++;
               if (sq.size() == 0) begin
                  errors++;
                  $display("FAIL read32_strobe[%0d] k=%0d: strobe seen, required none", i, k);
               end else begin
                  e = sq.pop_front();
                  if (k != 0 || b_reg_adr !== e.adr || b_reg_we !== e.we || b_reg_re !== ~e.we ||
                      (e.chk_dat && b_reg_dat !== e.dat)) begin
                     errors++;
                     $display("FAIL read32_strobe[%0d]: k=%0d adr=%h dat=%h we=%b re=%b, required k=0 adr=%h dat=%h we=%b",
                              i, k, b_reg_adr, b_reg_dat, b_reg_we, b_reg_re, e.adr, e.dat, e.we);
                  end
               end
            end
            if (b_ack) begin
               nack++;
               checks++;
               if (k != 1) begin
                  errors++;
                  $display("FAIL read32_ack_cycle[%0d]: ack at k=%0d, required k=1", i, k);
               end
               if (!t_we[i]) begin
                  checks++;
                  if (aq.size() == 0) begin
                     errors++;
                     $display("FAIL read32_data[%0d]: ack with no expected data", i);
                  end else begin
                     exp_w = aq.pop_front();
                     if (b_rdat !== exp_w) begin
                        errors++;
                        $display("FAIL read32_data[%0d]: dat_o=%h, required %h", i, b_rdat, exp_w);
                     end
                  end
               end
               b_cyc = 0; b_stb = 0;
            end
         end
         checks++;
         if (nstb != 1 || nack != 1 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL read32_count[%0d]: strobes=%0d acks=%0d err=%b, required 1 1 0", i, nstb, nack, b_err);
         end
      end
   endtask

   task automatic test_err();
      logic [3:0] t_sel [3] = '{4'b0011, 4'b0000, 4'b1010};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         b_cyc = 1; b_stb = 1; b_we = (i != 1); b_adr = 5'h0C; b_wdat = 32'h1234_5678; b_sel = t_sel[i];
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (b_err !== (k == 0)) begin
               errors++;
               $display("FAIL err_pulse[%0d] k=%0d: err=%b, required %b", i, k, b_err, (k == 0));
            end
            checks++;
            if (b_reg_we || b_reg_re || b_ack) begin
               errors++;
               $display("FAIL err_nostrobe[%0d] k=%0d: we=%b re=%b ack=%b, required 0 0 0",
                        i, k, b_reg_we, b_reg_re, b_ack);
            end
            if (b_err) begin
               b_cyc = 0; b_stb = 0;
            end
         end
      end
   endtask

   task automatic test_abort();
      stb_exp_t    e;
      logic [31:0] exp_w;
      int nstb = 0;
      int nack = 0;
      @(negedge clk);
      sq.push_back('{adr: 5'h00, dat: 8'h00, we: 1'b0, chk_dat: 1'b0});
      c_cyc = 1; c_stb = 1; c_we = 0; c_adr = 5'h00; c_wdat = '0; c_sel = 4'b0001;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (c_reg_we || c_reg_re) begin
            nstb++;
            checks++;
            if (sq.size() == 0) begin
               errors++;
               $display("FAIL abort_strobe k=%0d: strobe seen, required none", k);
            end else begin
               e = sq.pop_front();
               if (k != (nstb == 1 ? 0 : 5) || c_reg_adr !== e.adr || c_reg_re !== 1'b1) begin
                  errors++;
                  $display("FAIL abort_strobe: k=%0d adr=%h re=%b, required k=%0d adr=%h re=1",
                           k, c_reg_adr, c_reg_re, (nstb == 1 ? 0 : 5), e.adr);
               end
            end
         end
         if (c_ack || c_err) begin
            nack++;
            checks++;
            if (k != 11 || c_err) begin
               errors++;
               $display("FAIL abort_ack: ack=%b err=%b at k=%0d, required ack only at k=11", c_ack, c_err, k);
            end
            checks++;
            if (aq.size() == 0) begin
               errors++;
               $display("FAIL abort_data: ack with no expected data");
            end else begin
               exp_w = aq.pop_front();
               if (c_rdat !== exp_w) begin
                  errors++;
                  $display("FAIL abort_data: dat_o=%h, required %h", c_rdat, exp_w);
               end
            end
            c_cyc = 0; c_stb = 0;
         end
         if (k == 3) begin
            c_cyc = 0; c_stb = 0;
         end
         if (k == 4) begin
            sq.push_back('{adr: 5'h05, dat: 8'h00, we: 1'b0, chk_dat: 1'b0});
            aq.push_back({16'h0, core_rd(5'h05), 8'h00});
            c_cyc = 1; c_stb = 1; c_adr = 5'h04; c_sel = 4'b0010;
         end
      end
      checks++;
      if (nstb != 2 || nack != 1) begin
         errors++;
         $display("FAIL abort_count: strobes=%0d acks=%0d, required 2 and 1", nstb, nack);
      end
   endtask

   task automatic test_back_to_back();
      stb_exp_t    e;
      logic [31:0] exp_w;
      int nstb = 0;
      int nack = 0;
      @(negedge clk);
      sq.push_back('{adr: 5'd1, dat: 8'h11, we: 1'b1, chk_dat: 1'b1});
      a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 5'd1; a_wdat = 8'h11; a_sel = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++;
         if (a_reg_we && a_reg_re) begin
            errors++;
            $display("FAIL b2b_excl k=%0d: we=%b re=%b, required not both", k, a_reg_we, a_reg_re);
         end
         if (a_reg_we || a_reg_re) begin
            nstb++;
            checks++;
            if (sq.size() == 0) begin
               errors++;
               $display("FAIL b2b_strobe k=%0d: extra strobe, required none", k);
            end else begin
               e = sq.pop_front();
               if (k != (nstb == 1 ? 0 : 4) || a_reg_adr !== e.adr || a_reg_we !== e.we ||
                   (e.chk_dat && a_reg_dat !== e.dat)) begin
                  errors++;
                  $display("FAIL b2b_strobe: k=%0d adr=%h dat=%h we=%b, required k=%0d adr=%h dat=%h we=%b",
                           k, a_reg_adr, a_reg_dat, a_reg_we, (nstb == 1 ? 0 : 4), e.adr, e.dat, e.we);
               end
            end
         end
         if (a_ack) begin
            nack++;
            checks++;
            if (k != (nack == 1 ? 2 : 6)) begin
               errors++;
               $display("FAIL b2b_ack_cycle: ack %0d at k=%0d, required k=%0d", nack, k, (nack == 1 ? 2 : 6));
            end
            if (nack == 1) begin
               sq.push_back('{adr: 5'd2, dat: 8'h00, we: 1'b0, chk_dat: 1'b0});
               aq.push_back({24'h0, core_rd(5'd2)});
               a_we = 0; a_adr = 5'd2; a_wdat = 8'h00;
            end else begin
               checks++;
               exp_w = (aq.size() != 0) ? aq.pop_front() : 32'hFFFF_FFFF;
               if ({24'h0, a_rdat} !== exp_w) begin
                  errors++;
                  $display("FAIL b2b_read_data: dat_o=%h, required %h", a_rdat, exp_w);
               end
               a_cyc = 0; a_stb = 0;
            end
         end
      end
      checks++;
      if (nstb != 2 || nack != 2) begin
         errors++;
         $display("FAIL b2b_count: strobes=%0d acks=%0d, required 2 and 2", nstb, nack);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] exp_w;
      int nack = 0;
      @(negedge clk);
      sq.push_back('{adr: 5'd7, dat: 8'h00, we: 1'b0, chk_dat: 1'b0});
      a_cyc = 1; a_stb = 1; a_we = 0; a_adr = 5'd7; a_sel = 1'b1;
      @(negedge clk);
      checks++;
      if (!a_reg_re || a_reg_adr !== 5'd7 || sq.size() == 0) begin
         errors++;
         $display("FAIL rstmid_strobe: re=%b adr=%h, required re=1 adr=07", a_reg_re, a_reg_adr);
      end
      if (sq.size() != 0) void'(sq.pop_front());
      @(negedge clk);
      checks++;
      if (a_ack || a_reg_re || a_reg_adr !== 5'd7) begin
         errors++;
         $display("FAIL rstmid_wait: ack=%b re=%b adr=%h, required 0 0 07", a_ack, a_reg_re, a_reg_adr);
      end
      rst_n = 1'b0;
      a_cyc = 0; a_stb = 0;
      #1;
      checks++;
      if ({a_rdat, a_ack, a_err, a_reg_adr, a_reg_dat, a_reg_we, a_reg_re} !== '0) begin
         errors++;
         $display("FAIL rstmid_clear: dat=%h ack=%b adr=%h rdat=%h, required all 0",
                  a_rdat, a_ack, a_reg_adr, a_reg_dat);
      end
      @(negedge clk);
      checks++;
      if (a_ack) begin
         errors++;
         $display("FAIL rstmid_noack: ack=%b during reset, required 0", a_ack);
      end
      rst_n = 1'b1;
      aq.push_back({24'h0, core_rd(5'd4)});
      a_cyc = 1; a_stb = 1; a_we = 0; a_adr = 5'd4;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) begin
            checks++;
            if (!a_reg_re || a_reg_adr !== 5'd4) begin
               errors++;
               $display("FAIL rstmid_after_strobe: re=%b adr=%h, required re=1 adr=04", a_reg_re, a_reg_adr);
            end
         end
         if (a_ack) begin
            nack++;
            checks++;
            exp_w = (aq.size() != 0) ? aq.pop_front() : 32'hFFFF_FFFF;
            if (k != 2 || {24'h0, a_rdat} !== exp_w) begin
               errors++;
               $display("FAIL rstmid_after_read: k=%0d dat=%h, required k=2 dat=%h", k, a_rdat, exp_w);
            end
            a_cyc = 0; a_stb = 0;
         end
      end
      checks++;
      if (nack != 1) begin
         errors++;
         $display("FAIL rstmid_after_count: acks=%0d, required 1", nack);
      end
   endtask

   initial begin
      test_reset();
      test_write8();
      test_read32();
      test_err();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (sq.size() != 0 || aq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d strobes and %0d reads left, required 0 and 0", sq.size(), aq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
